// File: rtl/alarm_control_core.sv
// alarm_control_core
//
// Control core of the alarm clock. It takes keypad digits from the keyboard
// interface, builds a four-digit BCD entry, strobes that entry into either
// the clock counter (load_new_time) or the alarm register (load_alarm),
// holds the alarm time, chooses what the display shows, and drives the
// ringing/snooze/stop behaviour of the alarm.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous reset, active low
//   one_second    single-clk pulse once per second
//   one_minute    single-clk pulse once per minute
//   key           PS/2 set-2 code of the held key, 8'h00 when no key
//   current_time  BCD HHMM from the clock counter
//   do_snooze     single-clk snooze button pulse
//   stop_alarm    single-clk alarm-off button pulse
//   key_buffer    digits entered so far, BCD HHMM
//   load_new_time one-clk strobe, clock counter loads key_buffer
//   load_alarm    one-clk strobe, alarm register loads key_buffer
//   show_alarm    display shows alarm_time instead of current_time
//   show_keyboard key entry in progress
//   alarm_time    stored alarm time, BCD HHMM
//   display       show_alarm ? alarm_time : current_time
//   sound_alarm   alarm ringing
//   debug_state   controller state encoding
//   debug_seconds controller seconds counter

module alarm_control_core #(
  parameter int ENTRY_TIMEOUT_S = 10,
  parameter int SHOW_ALARM_S    = 5,
  parameter int SNOOZE_MIN      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        one_minute,
  input  logic [7:0]  key,
  input  logic [15:0] current_time,
  input  logic        do_snooze,
  input  logic        stop_alarm,
  output logic [15:0] key_buffer,
  output logic        load_new_time,
  output logic        load_alarm,
  output logic        show_alarm,
  output logic        show_keyboard,
  output logic [15:0] alarm_time,
  output logic [15:0] display,
  output logic        sound_alarm,
  output logic [3:0]  debug_state,
  output logic [7:0]  debug_seconds
);

  localparam logic [7:0] ENTRY_LIMIT  = 8'(ENTRY_TIMEOUT_S);
  localparam logic [7:0] SHOW_LIMIT   = 8'(SHOW_ALARM_S);
  localparam logic [7:0] SNOOZE_LIMIT = 8'(SNOOZE_MIN);

  localparam logic [7:0] CODE_STAR  = 8'h7C;
  localparam logic [7:0] CODE_MINUS = 8'h7B;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    KEY_ENTRY  = 4'd1,
    LOAD_TIME  = 4'd2,
    LOAD_ALARM = 4'd3,
    SHOW_ALARM = 4'd4
  } state_t;

  state_t      state;
  logic [7:0]  key_r;
  logic [7:0]  key_prev;
  logic        key_press;
  logic        is_digit;
  logic        is_star;
  logic        is_minus;
  logic [3:0]  digit_val;
  logic [7:0]  seconds;
  logic        match;
  logic        match_prev;
  logic        snooze_armed;
  logic [7:0]  snooze_count;

  // Two-stage key register: the second stage lets us see the 00 -> nonzero
  // transition so a held key produces exactly one action.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r    <= 8'h00;
      key_prev <= 8'h00;
    end else begin
      key_r    <= key;
      key_prev <= key_r;
    end
  end

  assign key_press = (key_prev == 8'h00) && (key_r != 8'h00);

  // Decode the registered PS/2 code into digit / '*' / '-' classes.
  always_comb begin
    is_digit  = 1'b1;
    digit_val = 4'd0;
    case (key_r)
      8'h70:   digit_val = 4'd0;
      8'h69:   digit_val = 4'd1;
      8'h72:   digit_val = 4'd2;
      8'h7A:   digit_val = 4'd3;
      8'h6B:   digit_val = 4'd4;
      8'h73:   digit_val = 4'd5;
      8'h74:   digit_val = 4'd6;
      8'h6C:   digit_val = 4'd7;
      8'h75:   digit_val = 4'd8;
      8'h7D:   digit_val = 4'd9;
      default: is_digit  = 1'b0;
    endcase
    is_star  = (key_r == CODE_STAR);
    is_minus = (key_r == CODE_MINUS);
  end

  // Entry controller. Flag outputs are set on the transition into the state
  // they belong to, so they are registered and line up with debug_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      key_buffer    <= 16'h0000;
      alarm_time    <= 16'h0000;
      seconds       <= 8'd0;
      load_new_time <= 1'b0;
      load_alarm    <= 1'b0;
      show_alarm    <= 1'b0;
      show_keyboard <= 1'b0;
    end else begin
      load_new_time <= 1'b0;
      load_alarm    <= 1'b0;
      case (state)
        IDLE: begin
          if (key_press && is_digit) begin
            key_buffer    <= {12'h000, digit_val};
            seconds       <= 8'd0;
            state         <= KEY_ENTRY;
            show_keyboard <= 1'b1;
          end else if (key_press && is_star) begin
            seconds    <= 8'd0;
            state      <= SHOW_ALARM;
            show_alarm <= 1'b1;
          end
        end
        KEY_ENTRY: begin
          if (key_press && is_digit) begin
            key_buffer <= {key_buffer[11:0], digit_val};
            seconds    <= 8'd0;
          end else if (key_press && is_minus) begin
            state         <= LOAD_TIME;
            load_new_time <= 1'b1;
            show_keyboard <= 1'b0;
          end else if (key_press && is_star) begin
            state         <= LOAD_ALARM;
            load_alarm    <= 1'b1;
            alarm_time    <= key_buffer;
            show_keyboard <= 1'b0;
          end else if (one_second) begin
            // Abandoned entry: drop the partial digits.
            if (seconds + 8'd1 >= ENTRY_LIMIT) begin
              state         <= IDLE;
              key_buffer    <= 16'h0000;
              seconds       <= 8'd0;
              show_keyboard <= 1'b0;
            end else begin
              seconds <= seconds + 8'd1;
            end
          end
        end
        LOAD_TIME:  state <= IDLE;
        LOAD_ALARM: state <= IDLE;
        SHOW_ALARM: begin
          if (key_press || (one_second && (seconds + 8'd1 >= SHOW_LIMIT))) begin
            state      <= IDLE;
            seconds    <= 8'd0;
            show_alarm <= 1'b0;
          end else if (one_second) begin
            seconds <= seconds + 8'd1;
          end
        end
        default: begin
          state         <= IDLE;
          show_alarm    <= 1'b0;
          show_keyboard <= 1'b0;
        end
      endcase
    end
  end

  assign match = (current_time == alarm_time);

  // Alarm driver. match_prev resets to 1 so that 00:00 == 00:00 straight
  // out of reset is not seen as a new match. stop_alarm has top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sound_alarm  <= 1'b0;
      snooze_armed <= 1'b0;
      snooze_count <= 8'd0;
      match_prev   <= 1'b1;
    end else begin
      match_prev <= match;
      if (stop_alarm) begin
        sound_alarm  <= 1'b0;
        snooze_armed <= 1'b0;
        snooze_count <= 8'd0;
      end else if (do_snooze && sound_alarm) begin
        sound_alarm  <= 1'b0;
        snooze_armed <= 1'b1;
        snooze_count <= 8'd0;
      end else begin
        if (match && !match_prev) begin
          sound_alarm <= 1'b1;
        end
        if (snooze_armed && one_minute) begin
          if (snooze_count + 8'd1 >= SNOOZE_LIMIT) begin
            sound_alarm  <= 1'b1;
            snooze_armed <= 1'b0;
            snooze_count <= 8'd0;
          end else begin
            snooze_count <= snooze_count + 8'd1;
          end
        end
      end
    end
  end

  assign display       = show_alarm ? alarm_time : current_time;
  assign debug_state   = state;
  assign debug_seconds = seconds;

endmodule

// File: tb/tb_alarm_control_core.sv
// tb_alarm_control_core
//
// Scenario bench for alarm_control_core. Each test_* task drives one
// feature with randomized digits/timing and compares the outputs with a
// small behavioural model (entry value as a base-16 number, stored alarm,
// expected ringing status).

module tb_alarm_control_core;

  localparam int ENTRY_TIMEOUT_S = 10;
  localparam int SHOW_ALARM_S    = 5;
  localparam int SNOOZE_MIN      = 10;

  localparam logic [7:0] KEY_STAR  = 8'h7C;
  localparam logic [7:0] KEY_MINUS = 8'h7B;
  localparam logic [15:0] IDLE_TIME = 16'hABCD;

  logic        clk;
  logic        reset;
  logic        one_second;
  logic        one_minute;
  logic [7:0]  key;
  logic [15:0] current_time;
  logic        do_snooze;
  logic        stop_alarm;
  logic [15:0] key_buffer;
  logic        load_new_time;
  logic        load_alarm;
  logic        show_alarm;
  logic        show_keyboard;
  logic [15:0] alarm_time;
  logic [15:0] display;
  logic        sound_alarm;
  logic [3:0]  debug_state;
  logic [7:0]  debug_seconds;

  logic [7:0]  digit_code [10];
  int          checks;
  int          passed;
  int          strobe_time_cnt;
  int          strobe_alarm_cnt;
  logic [15:0] m_key_buffer;
  logic [15:0] m_alarm_time;

  alarm_control_core #(
    .ENTRY_TIMEOUT_S(ENTRY_TIMEOUT_S),
    .SHOW_ALARM_S(SHOW_ALARM_S),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .one_second(one_second),
    .one_minute(one_minute),
    .key(key),
    .current_time(current_time),
    .do_snooze(do_snooze),
    .stop_alarm(stop_alarm),
    .key_buffer(key_buffer),
    .load_new_time(load_new_time),
    .load_alarm(load_alarm),
    .show_alarm(show_alarm),
    .show_keyboard(show_keyboard),
    .alarm_time(alarm_time),
    .display(display),
    .sound_alarm(sound_alarm),
    .debug_state(debug_state),
    .debug_seconds(debug_seconds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a key for three clocks, release for three, counting strobes seen.
  task automatic press_key(input logic [7:0] code);
    key = code;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (load_new_time) strobe_time_cnt++;
      if (load_alarm) strobe_alarm_cnt++;
      if (i == 2) key = 8'h00;
    end
  endtask

  task automatic pulse_second();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
  endtask

  task automatic pulse_minute();
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
  endtask

  // Model of entering a digit: the buffer behaves like a base-16 number
  // that keeps only its four lowest digits.
  function automatic logic [15:0] append_digit(input logic [15:0] buf_val, input int d);
    return 16'((int'(buf_val) * 16 + d) % 65536);
  endfunction

  task automatic test_reset();
    reset        = 1'b0;
    current_time = 16'h0000;
    #3;
    checks++; if (key_buffer !== 16'h0000) $display("[TB] FAIL reset key_buffer: got %h expected 0000", key_buffer); else passed++;
    checks++; if (alarm_time !== 16'h0000) $display("[TB] FAIL reset alarm_time: got %h expected 0000", alarm_time); else passed++;
    checks++; if ({load_new_time, load_alarm, show_alarm, show_keyboard, sound_alarm} !== 5'b0) $display("[TB] FAIL reset flags: got %b expected 00000", {load_new_time, load_alarm, show_alarm, show_keyboard, sound_alarm}); else passed++;
    checks++; if (debug_state !== 4'd0) $display("[TB] FAIL reset debug_state: got %0d expected 0", debug_state); else passed++;
    checks++; if (debug_seconds !== 8'd0) $display("[TB] FAIL reset debug_seconds: got %0d expected 0", debug_seconds); else passed++;
    checks++; if (display !== 16'h0000) $display("[TB] FAIL reset display: got %h expected 0000", display); else passed++;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL no alarm at 0000 after reset: got %b expected 0", sound_alarm); else passed++;
    m_key_buffer = 16'h0000;
    m_alarm_time = 16'h0000;
    current_time = IDLE_TIME;
    tick();
  endtask

  task automatic test_set_time();
    int fixed_digits [4] = '{1, 2, 3, 4};
    for (int iter = 0; iter < 3; iter++) begin
      int n;
      n = (iter == 0) ? 4 : int'($urandom_range(1, 6));
      m_key_buffer = 16'h0000;
      for (int j = 0; j < n; j++) begin
        int d;
        d = (iter == 0) ? fixed_digits[j] : int'($urandom_range(0, 9));
        press_key(digit_code[d]);
        m_key_buffer = append_digit(m_key_buffer, d);
        checks++; if (key_buffer !== m_key_buffer) $display("[TB] FAIL entry key_buffer: got %h expected %h", key_buffer, m_key_buffer); else passed++;
      end
      checks++; if (show_keyboard !== 1'b1 || debug_state !== 4'd1) $display("[TB] FAIL entry show_keyboard/state: got %b/%0d expected 1/1", show_keyboard, debug_state); else passed++;
      strobe_time_cnt  = 0;
      strobe_alarm_cnt = 0;
      press_key(KEY_MINUS);
      checks++; if (strobe_time_cnt !== 1) $display("[TB] FAIL load_new_time cycles: got %0d expected 1", strobe_time_cnt); else passed++;
      checks++; if (strobe_alarm_cnt !== 0) $display("[TB] FAIL load_alarm during time load: got %0d expected 0", strobe_alarm_cnt); else passed++;
      checks++; if (debug_state !== 4'd0 || show_keyboard !== 1'b0) $display("[TB] FAIL after time load state/show_keyboard: got %0d/%b expected 0/0", debug_state, show_keyboard); else passed++;
      checks++; if (key_buffer !== m_key_buffer) $display("[TB] FAIL key_buffer retained: got %h expected %h", key_buffer, m_key_buffer); else passed++;
    end
  endtask

  task automatic test_set_alarm();
    int fixed_digits [4] = '{0, 7, 3, 0};
    for (int iter = 0; iter < 3; iter++) begin
      m_key_buffer = 16'h0000;
      for (int j = 0; j < 4; j++) begin
        int d;
        d = (iter == 2) ? fixed_digits[j] : int'($urandom_range(0, 9));
        press_key(digit_code[d]);
        m_key_buffer = append_digit(m_key_buffer, d);
      end
      strobe_time_cnt  = 0;
      strobe_alarm_cnt = 0;
      press_key(KEY_STAR);
      m_alarm_time = m_key_buffer;
      checks++; if (strobe_alarm_cnt !== 1) $display("[TB] FAIL load_alarm cycles: got %0d expected 1", strobe_alarm_cnt); else passed++;
      checks++; if (strobe_time_cnt !== 0) $display("[TB] FAIL load_new_time during alarm load: got %0d expected 0", strobe_time_cnt); else passed++;
      checks++; if (alarm_time !== m_alarm_time) $display("[TB] FAIL alarm_time: got %h expected %h", alarm_time, m_alarm_time); else passed++;
      checks++; if (debug_state !== 4'd0) $display("[TB] FAIL after alarm load state: got %0d expected 0", debug_state); else passed++;
    end
  endtask

  task automatic test_show_alarm();
    int d;
    press_key(KEY_STAR);
    checks++; if (show_alarm !== 1'b1 || debug_state !== 4'd4) $display("[TB] FAIL show_alarm entry: got %b/%0d expected 1/4", show_alarm, debug_state); else passed++;
    checks++; if (display !== m_alarm_time) $display("[TB] FAIL display alarm: got %h expected %h", display, m_alarm_time); else passed++;
    for (int i = 1; i <= SHOW_ALARM_S; i++) begin
      logic exp_show;
      logic [15:0] exp_disp;
      pulse_second();
      exp_show = (i < SHOW_ALARM_S);
      exp_disp = exp_show ? m_alarm_time : IDLE_TIME;
      checks++; if (show_alarm !== exp_show || display !== exp_disp) $display("[TB] FAIL show_alarm after %0d s: got %b/%h expected %b/%h", i, show_alarm, display, exp_show, exp_disp); else passed++;
    end
    checks++; if (debug_state !== 4'd0) $display("[TB] FAIL show_alarm timeout state: got %0d expected 0", debug_state); else passed++;
    // Any key leaves SHOW_ALARM without touching the entry buffer.
    press_key(KEY_STAR);
    d = int'($urandom_range(0, 9));
    press_key(digit_code[d]);
    checks++; if (show_alarm !== 1'b0 || debug_state !== 4'd0) $display("[TB] FAIL show_alarm key abort: got %b/%0d expected 0/0", show_alarm, debug_state); else passed++;
    checks++; if (key_buffer !== m_key_buffer) $display("[TB] FAIL key_buffer after abort: got %h expected %h", key_buffer, m_key_buffer); else passed++;
  endtask

  task automatic test_timeout();
    int k;
    strobe_time_cnt  = 0;
    strobe_alarm_cnt = 0;
    press_key(digit_code[5]);
    checks++; if (key_buffer !== 16'h0005 || debug_state !== 4'd1) $display("[TB] FAIL timeout entry: got %h/%0d expected 0005/1", key_buffer, debug_state); else passed++;
    for (int i = 1; i <= ENTRY_TIMEOUT_S; i++) begin
      logic [3:0] exp_state;
      pulse_second();
      exp_state = (i < ENTRY_TIMEOUT_S) ? 4'd1 : 4'd0;
      if (i >= ENTRY_TIMEOUT_S - 1) begin
        checks++; if (debug_state !== exp_state) $display("[TB] FAIL timeout state after %0d s: got %0d expected %0d", i, debug_state, exp_state); else passed++;
      end
      if (load_new_time || load_alarm) strobe_time_cnt++;
    end
    checks++; if (key_buffer !== 16'h0000) $display("[TB] FAIL timeout key_buffer: got %h expected 0000", key_buffer); else passed++;
    checks++; if (strobe_time_cnt !== 0 || strobe_alarm_cnt !== 0) $display("[TB] FAIL timeout strobes: got %0d/%0d expected 0/0", strobe_time_cnt, strobe_alarm_cnt); else passed++;
    // A digit mid-entry restarts the timeout.
    press_key(digit_code[$urandom_range(0, 9)]);
    k = int'($urandom_range(1, ENTRY_TIMEOUT_S - 1));
    repeat (k) pulse_second();
    press_key(digit_code[$urandom_range(0, 9)]);
    repeat (ENTRY_TIMEOUT_S - 1) pulse_second();
    checks++; if (debug_state !== 4'd1) $display("[TB] FAIL timeout restarted by digit: got %0d expected 1", debug_state); else passed++;
    pulse_second();
    checks++; if (debug_state !== 4'd0 || key_buffer !== 16'h0000) $display("[TB] FAIL restarted timeout expiry: got %0d/%h expected 0/0000", debug_state, key_buffer); else passed++;
    m_key_buffer = 16'h0000;
  endtask

  task automatic test_alarm_snooze();
    current_time = 16'h0729;
    repeat (2) tick();
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL alarm before match: got %b expected 0", sound_alarm); else passed++;
    current_time = m_alarm_time;
    tick();
    checks++; if (sound_alarm !== 1'b1) $display("[TB] FAIL alarm on match: got %b expected 1", sound_alarm); else passed++;
    do_snooze = 1'b1;
    tick();
    do_snooze = 1'b0;
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL snooze silences: got %b expected 0", sound_alarm); else passed++;
    for (int i = 1; i <= SNOOZE_MIN; i++) begin
      logic exp_sound;
      repeat ($urandom_range(0, 3)) tick();
      pulse_minute();
      exp_sound = (i >= SNOOZE_MIN);
      if (i >= SNOOZE_MIN - 1) begin
        checks++; if (sound_alarm !== exp_sound) $display("[TB] FAIL snooze after %0d min: got %b expected %b", i, sound_alarm, exp_sound); else passed++;
      end
    end
    stop_alarm = 1'b1;
    tick();
    stop_alarm = 1'b0;
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL stop_alarm: got %b expected 0", sound_alarm); else passed++;
    repeat (SNOOZE_MIN + 2) pulse_minute();
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL re-sound after stop: got %b expected 0", sound_alarm); else passed++;
    do_snooze = 1'b1;
    tick();
    do_snooze = 1'b0;
    repeat (SNOOZE_MIN + 1) pulse_minute();
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL snooze while silent: got %b expected 0", sound_alarm); else passed++;
  endtask

  task automatic test_snooze_stop_same_clk();
    current_time = 16'h0731;
    tick();
    current_time = m_alarm_time;
    tick();
    checks++; if (sound_alarm !== 1'b1) $display("[TB] FAIL alarm on second match: got %b expected 1", sound_alarm); else passed++;
    do_snooze  = 1'b1;
    stop_alarm = 1'b1;
    tick();
    do_snooze  = 1'b0;
    stop_alarm = 1'b0;
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL snooze+stop: got %b expected 0", sound_alarm); else passed++;
    repeat (SNOOZE_MIN + 2) pulse_minute();
    checks++; if (sound_alarm !== 1'b0) $display("[TB] FAIL snooze armed despite stop: got %b expected 0", sound_alarm); else passed++;
  endtask

  task automatic test_async_reset();
    current_time = IDLE_TIME;
    press_key(digit_code[$urandom_range(1, 9)]);
    press_key(digit_code[$urandom_range(1, 9)]);
    checks++; if (debug_state !== 4'd1) $display("[TB] FAIL pre-reset entry state: got %0d expected 1", debug_state); else passed++;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (key_buffer !== 16'h0000 || alarm_time !== 16'h0000) $display("[TB] FAIL async reset registers: got %h/%h expected 0000/0000", key_buffer, alarm_time); else passed++;
    checks++; if (debug_state !== 4'd0 || show_keyboard !== 1'b0 || sound_alarm !== 1'b0) $display("[TB] FAIL async reset state: got %0d/%b/%b expected 0/0/0", debug_state, show_keyboard, sound_alarm); else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (display !== IDLE_TIME || sound_alarm !== 1'b0) $display("[TB] FAIL after reset release: got %h/%b expected %h/0", display, sound_alarm, IDLE_TIME); else passed++;
  endtask

  initial begin
    digit_code   = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    checks       = 0;
    passed       = 0;
    reset        = 1'b0;
    one_second   = 1'b0;
    one_minute   = 1'b0;
    key          = 8'h00;
    current_time = 16'h0000;
    do_snooze    = 1'b0;
    stop_alarm   = 1'b0;
    strobe_time_cnt  = 0;
    strobe_alarm_cnt = 0;
    $display("[TB] starting alarm_control_core scenarios");
    test_reset();
    test_set_time();
    test_set_alarm();
    test_show_alarm();
    test_timeout();
    test_alarm_snooze();
    test_snooze_stop_same_clk();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alarm_control_core.md
Name: alarm_control_core

Overview:
Control core of the alarm clock, merging three functions: keypad-entry controller, alarm-time register, and display/alarm driver. It sits between the keyboard interface and clock counter (upstream) and the 7-segment driver (downstream). It accepts digit entry, issues load-time and load-alarm strobes, holds the alarm time, selects the displayed time, and raises/snoozes/stops the alarm.

Parameters:
ENTRY_TIMEOUT_S, 10, seconds without a keypress before KEY_ENTRY aborts
SHOW_ALARM_S, 5, seconds SHOW_ALARM is held
SNOOZE_MIN, 10, minutes of snooze before the alarm re-sounds

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
one_second  in  1  single-clk pulse, once per second
one_minute  in  1  single-clk pulse, once per minute
key  in  8  PS/2 set-2 code of the held key; 8'h00 = no key
current_time  in  16  BCD HHMM from clock counter
do_snooze  in  1  single-clk snooze button pulse
stop_alarm  in  1  single-clk alarm-off button pulse
key_buffer  out  16  entered digits, BCD HHMM
load_new_time  out  1  one-clk strobe: clock counter loads key_buffer
load_alarm  out  1  one-clk strobe: alarm register loads key_buffer
show_alarm  out  1  display alarm time instead of current time
show_keyboard  out  1  key entry active; top level shows key_buffer
alarm_time  out  16  stored alarm, BCD HHMM
display  out  16  show_alarm ? alarm_time : current_time (combinational)
sound_alarm  out  1  alarm ringing
debug_state  out  4  FSM state encoding
debug_seconds  out  8  controller seconds counter

Behaviour:
- Reset: FSM=IDLE, key_buffer=0, alarm_time=0, all strobes/flags 0, counters 0, snooze inactive, match-history register=1.
- Key press: 00->nonzero transition of registered key; one action per press; releases ignored.
- Codes: digits 0..9 = 70,69,72,7A,6B,73,74,6C,75,7D; '*'=7C; '-'=7B; all others ignored. No BCD range checking.
- States (debug_state): IDLE=0, KEY_ENTRY=1, LOAD_TIME=2, LOAD_ALARM=3, SHOW_ALARM=4.
- IDLE: digit -> key_buffer={12'h000,d}, seconds=0, go KEY_ENTRY. '*' -> seconds=0, go SHOW_ALARM.
- KEY_ENTRY: show_keyboard=1. Digit -> key_buffer={key_buffer[11:0],d}, seconds=0. '-' -> LOAD_TIME. '*' -> LOAD_ALARM. one_second increments seconds; reaching ENTRY_TIMEOUT_S -> IDLE with key_buffer cleared to 0.
- LOAD_TIME: load_new_time=1 for exactly one clk, then IDLE; key_buffer retained.
- LOAD_ALARM: load_alarm=1 for one clk; alarm_time<=key_buffer on the same edge; then IDLE.
- SHOW_ALARM: show_alarm=1. Any key press or seconds reaching SHOW_ALARM_S -> IDLE.
- Outputs are registered, except display.
- Alarm match: match=(current_time==alarm_time). Rising edge of match (current vs. previous clk) sets sound_alarm. Reset history=1 prevents a false alarm at 00:00==00:00.
- Snooze: do_snooze while sound_alarm=1 clears sound_alarm, arms snooze, count=0. one_minute increments count; at SNOOZE_MIN sound_alarm=1 and snooze disarms. do_snooze while silent is ignored.
- stop_alarm: clears sound_alarm and disarms snooze. stop_alarm wins over a simultaneous do_snooze or match edge.
- Async reset mid-operation returns all state to reset values immediately.

Test Plan:
- Reset low -> all outputs 0, display=current_time, sound_alarm stays 0 with current_time=0000.
- Keys 1,2,3,4,'-' -> key_buffer=1234, show_keyboard 1 during entry, load_new_time high exactly one clk, state returns 0.
- Keys 0,7,3,0,'*' -> load_alarm one clk, alarm_time=0730. Then '*' in IDLE -> show_alarm=1, display=0730 for 5 one_second pulses, then 0.
- Key 5, then 10 one_second pulses with no keys -> state IDLE, key_buffer=0000, no strobes.
- alarm_time=0730, current_time 0729->0730 -> sound_alarm=1. do_snooze -> 0. After 10 one_minute pulses -> 1. stop_alarm -> 0, no further re-sound.
- do_snooze and stop_alarm in same clk while ringing -> sound_alarm=0, snooze not armed.
